// File: rtl/control_arb_pkg.sv
// control_arb_pkg: state codes and default sizes shared by control_arb and contador_cond.
package control_arb_pkg;
    localparam int N_CH     = 4;
    localparam int UMBRAL_W = 3;
    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_INIT   = 4'd1,
        S_ERROR  = 4'd2,
        S_IDLE   = 4'd4,
        S_ACTIVE = 4'd8
    } state_t;
endpackage

// File: rtl/rr_arb4.sv
// rr_arb4: 4-way round-robin grant; search starts one past the last granted channel.
module rr_arb4 (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       enable,
    output logic [3:0] grant,
    output logic [1:0] idx
);
    logic [1:0] ptr;
    logic [1:0] c;
    logic       found;
    always_comb begin
        idx   = ptr;
        found = 1'b0;
        c     = '0;
        for (int k = 1; k <= 4; k++) begin
            c = ptr + 2'(k);
            if (!found && req[c]) begin
                found = 1'b1;
                idx   = c;
            end
        end
        grant = (enable && found) ? (4'b0001 << idx) : 4'b0000;
    end
    // Pointer resets to 3 so channel 0 wins first; it only moves on a real grant.
    always_ff @(posedge clk or negedge rst)
        if (!rst) ptr <= 2'd3;
        else if (|grant) ptr <= idx;
endmodule

// File: rtl/control_arb.sv
// control_arb: input-FIFO read arbiter with INIT/IDLE/ACTIVE/ERROR control FSM.
module control_arb #(
    parameter int UMBRAL_W = control_arb_pkg::UMBRAL_W,
    parameter int N_CH     = control_arb_pkg::N_CH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                init,
    input  logic [UMBRAL_W-1:0] umbral_alto_in,
    input  logic [UMBRAL_W-1:0] umbral_bajo_in,
    input  logic [N_CH-1:0]     fifo_empty,
    input  logic [N_CH-1:0]     fifo_error,
    input  logic                out_almost_full,
    output logic [3:0]          Estado,
    output logic [UMBRAL_W-1:0] umbral_alto,
    output logic [UMBRAL_W-1:0] umbral_bajo,
    output logic [N_CH-1:0]     pop,
    output logic [1:0]          sel_out,
    output logic                push_out,
    output logic                idle_out,
    output logic                active_out,
    output logic                error_out
);
    import control_arb_pkg::*;
    state_t     state, next;
    logic       any_err, enable;
    logic [1:0] idx;
    assign any_err = |fifo_error;
    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= S_RESET;
        else state <= next;
    always_comb begin
        next = state;
        case (state)
            S_RESET:  next = S_INIT;
            S_INIT:   next = init ? S_INIT : (umbral_bajo_in >= umbral_alto_in) ? S_ERROR : S_IDLE;
            S_IDLE:   next = any_err ? S_ERROR : init ? S_INIT : (~&fifo_empty) ? S_ACTIVE : S_IDLE;
            S_ACTIVE: next = any_err ? S_ERROR : init ? S_INIT : (&fifo_empty) ? S_IDLE : S_ACTIVE;
            S_ERROR:  next = S_ERROR;
            default:  next = S_RESET;
        endcase
    end
    always_comb begin
        Estado     = state;
        idle_out   = state == S_IDLE;
        active_out = state == S_ACTIVE;
        error_out  = state == S_ERROR;
        enable     = active_out && !out_almost_full && !init && !any_err;
    end
    rr_arb4 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req    (~fifo_empty),
        .enable (enable),
        .grant  (pop),
        .idx    (idx)
    );
    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            umbral_alto <= '0;
            umbral_bajo <= '0;
            push_out    <= 1'b0;
            sel_out     <= 2'd0;
        end else begin
            if (state == S_INIT) begin
                umbral_alto <= umbral_alto_in;
                umbral_bajo <= umbral_bajo_in;
            end
            push_out <= |pop;
            if (|pop) sel_out <= idx;
        end
endmodule

// File: tb/tb_control_arb.sv
// tb_control_arb: directed scenarios plus random traffic checked against a behavioural model.
module tb_control_arb;
    logic       clk = 1'b0, rst = 1'b0, init = 1'b0, out_almost_full = 1'b0;
    logic [2:0] alto_in = '0, bajo_in = '0;
    logic [3:0] fifo_empty = 4'hf, fifo_error = '0;
    logic [3:0] Estado, pop;
    logic [2:0] umbral_alto, umbral_bajo;
    logic [1:0] sel_out;
    logic       push_out, idle_out, active_out, error_out;
    int n_vec = 0, n_bad = 0;
    int m_st = 0, m_alto = 0, m_bajo = 0, m_ptr = 3, m_push = 0, m_sel = 0;

    control_arb dut (
        .clk(clk), .rst(rst), .init(init),
        .umbral_alto_in(alto_in), .umbral_bajo_in(bajo_in),
        .fifo_empty(fifo_empty), .fifo_error(fifo_error),
        .out_almost_full(out_almost_full),
        .Estado(Estado), .umbral_alto(umbral_alto), .umbral_bajo(umbral_bajo),
        .pop(pop), .sel_out(sel_out), .push_out(push_out),
        .idle_out(idle_out), .active_out(active_out), .error_out(error_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Channel the spec's round-robin rule grants this cycle, or -1 for none.
    function automatic int pick();
        if (m_st != 8 || out_almost_full || init || fifo_error != 0) return -1;
        for (int k = 1; k <= 4; k++) begin
            int c = (m_ptr + k) % 4;
            if (!fifo_empty[c]) return c;
        end
        return -1;
    endfunction

    task automatic check_outputs(output int g);
        g = pick();
        chk("estado", Estado, m_st);
        chk("pop", pop, g < 0 ? 0 : (1 << g));
        chk("push_out", push_out, m_push);
        if (m_push != 0) chk("sel_out", sel_out, m_sel);
        chk("idle_out", idle_out, m_st == 4);
        chk("active_out", active_out, m_st == 8);
        chk("error_out", error_out, m_st == 2);
        chk("umbral_alto", umbral_alto, m_alto);
        chk("umbral_bajo", umbral_bajo, m_bajo);
    endtask

    // Called at a negedge; applies inputs, checks, advances the model over one posedge.
    task automatic step(input logic i, input logic [3:0] fe, input logic [3:0] fer,
                        input logic af, input logic [2:0] a, input logic [2:0] b);
        int g, n;
        init = i; fifo_empty = fe; fifo_error = fer; out_almost_full = af;
        alto_in = a; bajo_in = b;
        #1;
        check_outputs(g);
        case (m_st)
            0: n = 1;
            1: n = i ? 1 : (b >= a) ? 2 : 4;
            4: n = (fer != 0) ? 2 : i ? 1 : (fe != 4'hf) ? 8 : 4;
            8: n = (fer != 0) ? 2 : i ? 1 : (fe == 4'hf) ? 4 : 8;
            default: n = 2;
        endcase
        @(posedge clk);
        if (m_st == 1) begin m_alto = a; m_bajo = b; end
        m_push = (g >= 0);
        if (g >= 0) begin m_ptr = g; m_sel = g; end
        m_st = n;
        @(negedge clk);
    endtask

    // Asserts reset off the clock edges and checks its immediate effect.
    task automatic do_reset();
        #3 rst = 1'b0;
        #1;
        m_st = 0; m_alto = 0; m_bajo = 0; m_ptr = 3; m_push = 0; m_sel = 0;
        chk("rst_estado", Estado, 0);
        chk("rst_pop", pop, 0);
        chk("rst_push_out", push_out, 0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        repeat (3) step(1, 4'hf, 0, 0, 6, 2);
        step(0, 4'hf, 0, 0, 6, 2);
        step(0, 4'hf, 0, 0, 0, 0);
        repeat (9) step(0, 4'h0, 0, 0, 0, 0);
        repeat (4) step(0, 4'b1010, 0, 0, 0, 0);
        repeat (2) step(0, 4'b1010, 0, 1, 0, 0);
        repeat (3) step(0, 4'b1010, 0, 0, 0, 0);
        do_reset();
        step(0, 4'h0, 0, 0, 6, 2);
        step(0, 4'h0, 0, 0, 6, 2);
        repeat (3) step(0, 4'h0, 0, 0, 0, 0);
        step(0, 4'h0, 4'b0100, 0, 0, 0);
        repeat (4) step(0, 4'h0, 0, 0, 0, 0);
        do_reset();
        step(0, 4'hf, 0, 0, 3, 3);
        step(0, 4'hf, 0, 0, 3, 3);
        repeat (2) step(0, 4'hf, 0, 0, 0, 0);
        do_reset();
        repeat (2) step(0, 4'h0, 0, 0, 6, 2);
        repeat (3) step(0, 4'h0, 0, 0, 0, 0);
        step(0, 4'hf, 0, 0, 0, 0);
        step(0, 4'hf, 0, 0, 0, 0);
        repeat (3) step(0, 4'h3, 0, 0, 0, 0);
        do_reset();
        for (int t = 0; t < 4000; t++) begin
            logic [2:0] a, b;
            if ($urandom_range(0, 249) == 0) do_reset();
            a = 3'($urandom_range(1, 7));
            b = ($urandom_range(0, 7) == 0) ? 3'($urandom) : 3'($urandom_range(0, int'(a) - 1));
            step($urandom_range(0, 15) == 0,
                 ($urandom_range(0, 5) == 0) ? 4'hf : 4'($urandom),
                 ($urandom_range(0, 399) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'h0,
                 $urandom_range(0, 3) == 0, a, b);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
